mem_responder: RTL and testbench

- Memory-side responder for the 5-stage core's two memory ports: serves instruction fetch (InstrAddr -> InstrMem) and data load/store (MemAddr/MemRead/MemWrite/WriteData -> MemData).
- Holds separate instruction and data word RAMs.
- After reset, a loader FSM fills instruction RAM through a valid/ready stream, then releases the core.
- Sits at top level beside PROCESSOR; its outputs connect directly to the core's InstrMem/MemData inputs.

---
 rtl/mem_responder.sv | 245 ++++++++++++++++++++++++
 tb/tb_mem_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the 5-stage core. Holds a separate instruction
//   RAM and data RAM (2^AW 32-bit words each). After Reset a loader FSM fills
//   the instruction RAM from a valid/ready stream, keeping the core in reset
//   (CoreHold) until the last word arrives. In RUN, instruction fetch and
//   data loads are combinational, and stores commit on the rising edge.
//
// Build option:
//   MEM_STATS_EN - when defined, builds saturating 16-bit counters of legal
//                  loads (ReadCount) and legal stores (WriteCount). When it
//                  is undefined, both ports are tied to zero and no counter
//                  flops exist.
//
// Ports:
//   Clock       in   1   system clock, rising edge
//   Reset       in   1   synchronous active-high reset
//   InstrAddr   in  16   instruction fetch byte address
//   InstrMem    out 32   fetched instruction (0 = NOP while loading/illegal)
//   MemAddr     in  16   data access byte address
//   MemRead     in   1   data load request
//   MemWrite    in   1   data store request
//   WriteData   in  32   store data
//   MemData     out 32   load data (0 when no legal load)
//   LoadValid   in   1   loader word valid
//   LoadData    in  32   loader word
//   LoadLast    in   1   final loader word marker
//   LoadReady   out  1   loader word accepted (high only in LOAD)
//   CoreHold    out  1   hold core in reset (high only in LOAD)
//   AccessErr   out  1   sticky illegal-access flag, cleared by Reset
//   ReadCount   out 16   legal load counter (MEM_STATS_EN)
//   WriteCount  out 16   legal store counter (MEM_STATS_EN)
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int AW = 10
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] InstrAddr,
  output logic [31:0] InstrMem,
  input  logic [15:0] MemAddr,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  output logic [31:0] MemData,
  input  logic        LoadValid,
  input  logic [31:0] LoadData,
  input  logic        LoadLast,
  output logic        LoadReady,
  output logic        CoreHold,
  output logic        AccessErr,
  output logic [15:0] ReadCount,
  output logic [15:0] WriteCount
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_r;
  state_t          stateNext_s;
  logic [AW-1:0]   loadPtr_r;
  logic            accessErr_r;

  logic [31:0]     iram_r [DEPTH];
  logic [31:0]     dram_r [DEPTH];

  logic            isLoad_s;
  logic            isRun_s;
  logic            loadXfer_s;
  logic            ptrAtEnd_s;
  logic            loadFinal_s;
  logic [AW-1:0]   instrIdx_s;
  logic [AW-1:0]   memIdx_s;
  logic            instrLegal_s;
  logic            memLegal_s;
  logic            memReq_s;
  logic            memConflict_s;
  logic            loadOk_s;
  logic            storeOk_s;
  logic            errEvent_s;

  // A byte address is legal when word aligned and every bit above the
  // word-index field is zero.
  function automatic logic addrLegal(input logic [15:0] addr);
    logic [15:0] highBits;
    highBits  = addr >> (AW + 2);
    addrLegal = (addr[1:0] == 2'b00) && (highBits == 16'd0);
  endfunction

  assign isLoad_s      = (state_r == LOAD);
  assign isRun_s       = (state_r == RUN);
  assign loadXfer_s    = isLoad_s && LoadValid;
  assign ptrAtEnd_s    = (loadPtr_r == {AW{1'b1}});
  // Filling the last RAM word ends the load even without LoadLast.
  assign loadFinal_s   = loadXfer_s && (LoadLast || ptrAtEnd_s);

  assign instrIdx_s    = InstrAddr[AW+1:2];
  assign memIdx_s      = MemAddr[AW+1:2];
  assign instrLegal_s  = addrLegal(InstrAddr);
  assign memLegal_s    = addrLegal(MemAddr);
  assign memReq_s      = MemRead || MemWrite;
  assign memConflict_s = MemRead && MemWrite;

  assign loadOk_s      = isRun_s && MemRead && !MemWrite && memLegal_s;
  assign storeOk_s     = isRun_s && MemWrite && !MemRead && memLegal_s;

  // Error sources: loader overflow, illegal fetch, simultaneous read/write,
  // or an illegal data address carrying a request.
  assign errEvent_s    = (loadXfer_s && ptrAtEnd_s && !LoadLast) ||
                         (isRun_s && (!instrLegal_s || memConflict_s ||
                                      (memReq_s && !memLegal_s)));

  // FSM state register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= LOAD;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      LOAD: begin
        if (loadFinal_s) begin
          stateNext_s = RUN;
        end else begin
          stateNext_s = LOAD;
        end
      end
      RUN: begin
        stateNext_s = RUN;
      end
      default: begin
        stateNext_s = LOAD;
      end
    endcase
  end

  // FSM outputs: handshake, hold and combinational read paths
  always_comb begin
    LoadReady = 1'b1;
    CoreHold  = 1'b1;
    InstrMem  = 32'd0;
    MemData   = 32'd0;
    case (state_r)
      LOAD: begin
        LoadReady = 1'b1;
        CoreHold  = 1'b1;
        InstrMem  = 32'd0;
        MemData   = 32'd0;
      end
      RUN: begin
        LoadReady = 1'b0;
        CoreHold  = 1'b0;
        if (instrLegal_s) begin
          InstrMem = iram_r[instrIdx_s];
        end else begin
          InstrMem = 32'd0;
        end
        if (loadOk_s) begin
          MemData = dram_r[memIdx_s];
        end else begin
          MemData = 32'd0;
        end
      end
      default: begin
        LoadReady = 1'b1;
        CoreHold  = 1'b1;
        InstrMem  = 32'd0;
        MemData   = 32'd0;
      end
    endcase
  end

  // Loader write pointer; restarts from word 0 on every reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      loadPtr_r <= {AW{1'b0}};
    end else if (loadXfer_s) begin
      loadPtr_r <= loadPtr_r + {{(AW-1){1'b0}}, 1'b1};
    end
  end

  // Sticky access-error flag
  always_ff @(posedge Clock) begin
    if (Reset) begin
      accessErr_r <= 1'b0;
    end else if (errEvent_s) begin
      accessErr_r <= 1'b1;
    end
  end

  assign AccessErr = accessErr_r;

  // Instruction RAM write port (loader only); contents survive reset
  always_ff @(posedge Clock) begin
    if (!Reset && loadXfer_s) begin
      iram_r[loadPtr_r] <= LoadData;
    end
  end

  // Data RAM write port (legal stores only); contents survive reset
  always_ff @(posedge Clock) begin
    if (!Reset && storeOk_s) begin
      dram_r[memIdx_s] <= WriteData;
    end
  end

`ifdef MEM_STATS_EN
  logic [15:0] readCount_r;
  logic [15:0] writeCount_r;

  // Saturating count of legal loads
  always_ff @(posedge Clock) begin
    if (Reset) begin
      readCount_r <= 16'd0;
    end else if (loadOk_s && (readCount_r != 16'hFFFF)) begin
      readCount_r <= readCount_r + 16'd1;
    end
  end

  // Saturating count of legal stores
  always_ff @(posedge Clock) begin
    if (Reset) begin
      writeCount_r <= 16'd0;
    end else if (storeOk_s && (writeCount_r != 16'hFFFF)) begin
      writeCount_r <= writeCount_r + 16'd1;
    end
  end

  assign ReadCount  = readCount_r;
  assign WriteCount = writeCount_r;
`else
  assign ReadCount  = 16'd0;
  assign WriteCount = 16'd0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: each stimulus cycle pushes its expected
// output values; they are popped and compared on the falling edge of that
// cycle, before the rising edge commits state.
module tb_mem_responder;

  localparam int AW = 10;

`ifdef MEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int K_INSTR = 0;
  localparam int K_MDATA = 1;
  localparam int K_HOLD  = 2;
  localparam int K_READY = 3;
  localparam int K_ERR   = 4;
  localparam int K_RCNT  = 5;
  localparam int K_WCNT  = 6;

  logic        Clock;
  logic        Reset;
  logic [15:0] InstrAddr;
  logic [31:0] InstrMem;
  logic [15:0] MemAddr;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] WriteData;
  logic [31:0] MemData;
  logic        LoadValid;
  logic [31:0] LoadData;
  logic        LoadLast;
  logic        LoadReady;
  logic        CoreHold;
  logic        AccessErr;
  logic [15:0] ReadCount;
  logic [15:0] WriteCount;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    int          kind;
    string       tag;
    logic [31:0] value;
  } sbEntry_t;

  sbEntry_t sbQ[$];

  mem_responder #(.AW(AW)) dut (
    .Clock(Clock), .Reset(Reset),
    .InstrAddr(InstrAddr), .InstrMem(InstrMem),
    .MemAddr(MemAddr), .MemRead(MemRead), .MemWrite(MemWrite),
    .WriteData(WriteData), .MemData(MemData),
    .LoadValid(LoadValid), .LoadData(LoadData), .LoadLast(LoadLast),
    .LoadReady(LoadReady), .CoreHold(CoreHold), .AccessErr(AccessErr),
    .ReadCount(ReadCount), .WriteCount(WriteCount)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_INSTR: observe = InstrMem;
      K_MDATA: observe = MemData;
      K_HOLD:  observe = {31'd0, CoreHold};
      K_READY: observe = {31'd0, LoadReady};
      K_ERR:   observe = {31'd0, AccessErr};
      K_RCNT:  observe = {16'd0, ReadCount};
      K_WCNT:  observe = {16'd0, WriteCount};
      default: observe = 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic pushExp(input int kind, input string tag, input logic [31:0] value);
    sbEntry_t e;
    e.kind  = kind;
    e.tag   = tag;
    e.value = value;
    sbQ.push_back(e);
  endtask

  // Compare everything queued for this cycle, then let the edge happen.
  task automatic step();
    sbEntry_t e;
    @(negedge Clock);
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkValue(e.tag, observe(e.kind), e.value);
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic idleInputs();
    InstrAddr = 16'd0;
    MemAddr   = 16'd0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    WriteData = 32'd0;
    LoadValid = 1'b0;
    LoadData  = 32'd0;
    LoadLast  = 1'b0;
  endtask

  task automatic doReset(input bit checkState);
    idleInputs();
    Reset = 1'b1;
    step();
    if (checkState) begin
      pushExp(K_HOLD,  "rstHold",   32'd1);
      pushExp(K_READY, "rstReady",  32'd1);
      pushExp(K_INSTR, "rstInstr",  32'd0);
      pushExp(K_MDATA, "rstMdata",  32'd0);
      pushExp(K_ERR,   "rstErr",    32'd0);
      pushExp(K_RCNT,  "rstRcnt",   32'd0);
      pushExp(K_WCNT,  "rstWcnt",   32'd0);
    end
    step();
    Reset = 1'b0;
  endtask

  task automatic loadWord(input logic [31:0] data, input logic last);
    LoadValid = 1'b1;
    LoadData  = data;
    LoadLast  = last;
    pushExp(K_HOLD, "holdInLoad", 32'd1);
    step();
    LoadValid = 1'b0;
    LoadLast  = 1'b0;
  endtask

  task automatic readInstr(input logic [15:0] addr, input logic [31:0] exp, input string tag);
    InstrAddr = addr;
    pushExp(K_INSTR, tag, exp);
    step();
    InstrAddr = 16'd0;
  endtask

  task automatic storeWord(input logic [15:0] addr, input logic [31:0] data);
    MemWrite  = 1'b1;
    MemAddr   = addr;
    WriteData = data;
    pushExp(K_MDATA, "mdataOnStore", 32'd0);
    step();
    MemWrite  = 1'b0;
  endtask

  task automatic loadData(input logic [15:0] addr, input logic [31:0] exp, input string tag);
    MemRead = 1'b1;
    MemAddr = addr;
    pushExp(K_MDATA, tag, exp);
    step();
    MemRead = 1'b0;
  endtask

  // Reset, load one word, confirm RUN with a clear error flag.
  task automatic freshRun();
    doReset(1'b0);
    loadWord(32'h0000_0000, 1'b1);
    pushExp(K_HOLD, "freshHold", 32'd0);
    pushExp(K_ERR,  "freshErr",  32'd0);
    step();
  endtask

  initial begin
    Reset = 1'b0;
    idleInputs();

    // Reset values and a 4-word program load
    doReset(1'b1);
    InstrAddr = 16'h0008;
    pushExp(K_INSTR, "instrNopInLoad", 32'd0);
    pushExp(K_READY, "readyInLoad",    32'd1);
    loadWord(32'h2001_0005, 1'b0);
    InstrAddr = 16'h0000;
    loadWord(32'h2002_0003, 1'b0);
    MemRead = 1'b1;
    MemAddr = 16'h0000;
    pushExp(K_MDATA, "mdataInLoad", 32'd0);
    loadWord(32'h0022_1820, 1'b0);
    MemRead = 1'b0;
    loadWord(32'h0000_0000, 1'b1);
    pushExp(K_HOLD,  "holdFalls",  32'd0);
    pushExp(K_READY, "readyFalls", 32'd0);
    readInstr(16'h0008, 32'h0022_1820, "instrWord2");
    readInstr(16'h0000, 32'h2001_0005, "instrWord0");
    readInstr(16'h0004, 32'h2002_0003, "instrWord1");

    // Store/load forwarding through the data RAM
    storeWord(16'h0010, 32'hDEAD_BEEF);
    loadData(16'h0010, 32'hDEAD_BEEF, "loadAfterStore");
    pushExp(K_MDATA, "mdataNoRead", 32'd0);
    step();
    storeWord(16'h0020, 32'h1111_1111);
    loadData(16'h0020, 32'h1111_1111, "load0x20");
    loadData(16'h0010, 32'hDEAD_BEEF, "load0x10Again");
    pushExp(K_ERR,  "errCleanRun", 32'd0);
    pushExp(K_RCNT, "readCount3",  STATS ? 32'd3 : 32'd0);
    pushExp(K_WCNT, "writeCount2", STATS ? 32'd2 : 32'd0);
    step();

    // Misaligned store is suppressed and flags an error
    freshRun();
    storeWord(16'h0013, 32'h5555_5555);
    pushExp(K_ERR, "errMisaligned", 32'd1);
    loadData(16'h0010, 32'hDEAD_BEEF, "word4Unchanged");
    pushExp(K_ERR, "errSticky", 32'd1);
    step();

    // Out-of-range load
    freshRun();
    loadData(16'h1000, 32'd0, "mdataOutOfRange");
    pushExp(K_ERR, "errOutOfRange", 32'd1);
    step();

    // Simultaneous read and write
    freshRun();
    MemWrite = 1'b1;
    WriteData = 32'h2222_2222;
    loadData(16'h0020, 32'd0, "mdataConflict");
    MemWrite = 1'b0;
    pushExp(K_ERR, "errConflict", 32'd1);
    loadData(16'h0020, 32'h1111_1111, "word8Unchanged");

    // Illegal instruction fetch
    freshRun();
    readInstr(16'h0002, 32'd0, "instrMisaligned");
    pushExp(K_ERR, "errInstrAddr", 32'd1);
    step();

    // Loader fills every word without LoadLast
    doReset(1'b0);
    for (int i = 0; i < (1 << AW); i++) begin
      loadWord(32'hC000_0000 | i, 1'b0);
    end
    pushExp(K_HOLD, "holdAfterFull", 32'd0);
    pushExp(K_ERR,  "errOverflow",   32'd1);
    readInstr(16'h0FFC, 32'hC000_03FF, "instrLastWord");

    // Gapped loader stream: only valid cycles store words
    doReset(1'b1);
    loadWord(32'hA000_0001, 1'b0);
    LoadData = 32'hBAD0_BAD0;
    pushExp(K_HOLD, "holdGap", 32'd1);
    step();
    loadWord(32'hA000_0002, 1'b0);
    pushExp(K_HOLD, "holdNoLast", 32'd1);
    step();
    loadWord(32'hA000_0003, 1'b1);
    readInstr(16'h0000, 32'hA000_0001, "gapWord0");
    readInstr(16'h0004, 32'hA000_0002, "gapWord1");
    readInstr(16'h0008, 32'hA000_0003, "gapWord2");

    // Reset after 2 of 5 words restarts the loader at word 0
    doReset(1'b0);
    loadWord(32'hE000_0000, 1'b0);
    loadWord(32'hE000_0001, 1'b0);
    doReset(1'b1);
    loadWord(32'hB000_0000, 1'b0);
    loadWord(32'hB000_0001, 1'b0);
    loadWord(32'hB000_0002, 1'b1);
    readInstr(16'h0000, 32'hB000_0000, "reloadWord0");
    readInstr(16'h0008, 32'hB000_0002, "reloadWord2");

    // Read counter saturation
    freshRun();
    MemRead = 1'b1;
    MemAddr = 16'h0010;
    for (int i = 0; i < 65540; i++) begin
      @(posedge Clock);
    end
    #1;
    MemRead = 1'b0;
    pushExp(K_RCNT, "readCountSat", STATS ? 32'h0000_FFFF : 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
